// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the 4-bit bus CPU.
//   - opcode constants (OP_NOP .. OP_HLT), upper nibble of the instruction register
//   - T-state constants T0..T4 for the five-step instruction cycle
//   - control-word bit indices, so that the sequencer, datapath blocks and any
//     bench all agree on which strobe lives where in a packed control word
package cpu_pkg;

    localparam int OPCODE_W = 4;
    localparam int STEP_W   = 3;

    // Opcodes
    localparam logic [OPCODE_W-1:0] OP_NOP = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_LDA = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_STA = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_LDI = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_JC  = 4'b0111;
    localparam logic [OPCODE_W-1:0] OP_JZ  = 4'b1000;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

    // T-states
    localparam logic [STEP_W-1:0] T0 = 3'd0;
    localparam logic [STEP_W-1:0] T1 = 3'd1;
    localparam logic [STEP_W-1:0] T2 = 3'd2;
    localparam logic [STEP_W-1:0] T3 = 3'd3;
    localparam logic [STEP_W-1:0] T4 = 3'd4;

    // Control-word bit indices
    localparam int CW_PC_INC    = 0;
    localparam int CW_PC_JUMP   = 1;
    localparam int CW_PC_OE     = 2;
    localparam int CW_MAR_LOAD  = 3;
    localparam int CW_RAM_OE    = 4;
    localparam int CW_RAM_WE    = 5;
    localparam int CW_IR_LOAD   = 6;
    localparam int CW_IR_OE     = 7;
    localparam int CW_A_LOAD    = 8;
    localparam int CW_A_OE      = 9;
    localparam int CW_B_LOAD    = 10;
    localparam int CW_ALU_OE    = 11;
    localparam int CW_ALU_SUB   = 12;
    localparam int CW_FLAG_LOAD = 13;
    localparam int CW_OUT_LOAD  = 14;
    localparam int CW_W         = 15;

    typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/step_counter.sv
// step_counter: mod-5 T-state counter (T0..T4, wraps T4 -> T0).
// Ports:
//   clk_i    rising-edge clock
//   clr_i    synchronous active-high clear, wins over hold
//   hold_i   freeze the count for this edge
//   count_o  current T-state
module step_counter
    import cpu_pkg::*;
(
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              hold_i,
    output logic [STEP_W-1:0] count_o
);

    logic [STEP_W-1:0] count_q;
    logic [STEP_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = T0;
        end else if (!hold_i) begin
            count_d = (count_q == T4) ? T0 : count_q + STEP_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired microcode sequencer for the 4-bit bus CPU.
// Every instruction takes five T-states: T0/T1 fetch, T2..T4 execute.
// Control strobes are combinational from (step, opcode, flags, halted, clr)
// and are consumed by their targets at the next rising edge.
// Ports:
//   clk, clr                    clock and synchronous active-high reset
//   opcode                      instruction opcode (IR upper nibble)
//   carry_flag, zero_flag       registered ALU flags, used by JC/JZ in T2
//   step                        current T-state (visibility)
//   halt                        high once HLT has executed, until clr
//   pc_inc..out_load            bus load / output-enable / count strobes
module control_sequencer
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                clr,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                carry_flag,
    input  logic                zero_flag,
    output logic [STEP_W-1:0]   step,
    output logic                halt,
    output logic                pc_inc,
    output logic                pc_jump,
    output logic                pc_oe,
    output logic                mar_load,
    output logic                ram_oe,
    output logic                ram_we,
    output logic                ir_load,
    output logic                ir_oe,
    output logic                a_load,
    output logic                a_oe,
    output logic                b_load,
    output logic                alu_oe,
    output logic                alu_sub,
    output logic                flag_load,
    output logic                out_load
);

    logic [STEP_W-1:0] step_q;
    logic              halted_q;
    logic              halted_d;
    logic              hlt_enter;
    ctrl_word_t        cw;

    // HLT is recognised on the edge leaving T2; the counter must not advance
    // on that same edge so step stays parked at T2 while halted.
    assign hlt_enter = !halted_q && (step_q == T2) && (opcode == OP_HLT);

    step_counter u_step_counter (
        .clk_i   (clk),
        .clr_i   (clr),
        .hold_i  (halted_q | hlt_enter),
        .count_o (step_q)
    );

    always_comb begin
        halted_d = halted_q | hlt_enter;
        if (clr) begin
            halted_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        halted_q <= halted_d;
    end

    // Decode. Fetch ignores the opcode; undefined opcodes and HLT fall
    // through to the all-zero default in execute.
    always_comb begin
        cw = '0;
        if (!clr && !halted_q) begin
            casez ({step_q, opcode})
                {T0, 4'b????}: begin
                    cw[CW_PC_OE]    = 1'b1;
                    cw[CW_MAR_LOAD] = 1'b1;
                end
                {T1, 4'b????}: begin
                    cw[CW_RAM_OE]  = 1'b1;
                    cw[CW_IR_LOAD] = 1'b1;
                    cw[CW_PC_INC]  = 1'b1;
                end
                {T2, OP_LDA}, {T2, OP_ADD}, {T2, OP_SUB}, {T2, OP_STA}: begin
                    cw[CW_IR_OE]    = 1'b1;
                    cw[CW_MAR_LOAD] = 1'b1;
                end
                {T2, OP_LDI}: begin
                    cw[CW_IR_OE]  = 1'b1;
                    cw[CW_A_LOAD] = 1'b1;
                end
                {T2, OP_JMP}: begin
                    cw[CW_IR_OE]   = 1'b1;
                    cw[CW_PC_JUMP] = 1'b1;
                end
                // Conditional jumps look at the live flags, so a flag change
                // during T2 is reflected in pc_jump within the same cycle.
                {T2, OP_JC}: begin
                    cw[CW_IR_OE]   = carry_flag;
                    cw[CW_PC_JUMP] = carry_flag;
                end
                {T2, OP_JZ}: begin
                    cw[CW_IR_OE]   = zero_flag;
                    cw[CW_PC_JUMP] = zero_flag;
                end
                {T2, OP_OUT}: begin
                    cw[CW_A_OE]     = 1'b1;
                    cw[CW_OUT_LOAD] = 1'b1;
                end
                {T3, OP_LDA}: begin
                    cw[CW_RAM_OE] = 1'b1;
                    cw[CW_A_LOAD] = 1'b1;
                end
                {T3, OP_ADD}, {T3, OP_SUB}: begin
                    cw[CW_RAM_OE] = 1'b1;
                    cw[CW_B_LOAD] = 1'b1;
                end
                {T3, OP_STA}: begin
                    cw[CW_A_OE]   = 1'b1;
                    cw[CW_RAM_WE] = 1'b1;
                end
                {T4, OP_ADD}: begin
                    cw[CW_ALU_OE]    = 1'b1;
                    cw[CW_A_LOAD]    = 1'b1;
                    cw[CW_FLAG_LOAD] = 1'b1;
                end
                {T4, OP_SUB}: begin
                    cw[CW_ALU_OE]    = 1'b1;
                    cw[CW_A_LOAD]    = 1'b1;
                    cw[CW_FLAG_LOAD] = 1'b1;
                    cw[CW_ALU_SUB]   = 1'b1;
                end
                default: begin
                    cw = '0;
                end
            endcase
        end
    end

    assign step      = step_q;
    assign halt      = halted_q;
    assign pc_inc    = cw[CW_PC_INC];
    assign pc_jump   = cw[CW_PC_JUMP];
    assign pc_oe     = cw[CW_PC_OE];
    assign mar_load  = cw[CW_MAR_LOAD];
    assign ram_oe    = cw[CW_RAM_OE];
    assign ram_we    = cw[CW_RAM_WE];
    assign ir_load   = cw[CW_IR_LOAD];
    assign ir_oe     = cw[CW_IR_OE];
    assign a_load    = cw[CW_A_LOAD];
    assign a_oe      = cw[CW_A_OE];
    assign b_load    = cw[CW_B_LOAD];
    assign alu_oe    = cw[CW_ALU_OE];
    assign alu_sub   = cw[CW_ALU_SUB];
    assign flag_load = cw[CW_FLAG_LOAD];
    assign out_load  = cw[CW_OUT_LOAD];

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;
    import cpu_pkg::*;

    typedef logic [STEP_W+CW_W:0] obs_t;  // {step, halt, control word}

    localparam ctrl_word_t M_PC_INC    = ctrl_word_t'(1) << CW_PC_INC;
    localparam ctrl_word_t M_PC_JUMP   = ctrl_word_t'(1) << CW_PC_JUMP;
    localparam ctrl_word_t M_PC_OE     = ctrl_word_t'(1) << CW_PC_OE;
    localparam ctrl_word_t M_MAR_LOAD  = ctrl_word_t'(1) << CW_MAR_LOAD;
    localparam ctrl_word_t M_RAM_OE    = ctrl_word_t'(1) << CW_RAM_OE;
    localparam ctrl_word_t M_RAM_WE    = ctrl_word_t'(1) << CW_RAM_WE;
    localparam ctrl_word_t M_IR_LOAD   = ctrl_word_t'(1) << CW_IR_LOAD;
    localparam ctrl_word_t M_IR_OE     = ctrl_word_t'(1) << CW_IR_OE;
    localparam ctrl_word_t M_A_LOAD    = ctrl_word_t'(1) << CW_A_LOAD;
    localparam ctrl_word_t M_A_OE      = ctrl_word_t'(1) << CW_A_OE;
    localparam ctrl_word_t M_B_LOAD    = ctrl_word_t'(1) << CW_B_LOAD;
    localparam ctrl_word_t M_ALU_OE    = ctrl_word_t'(1) << CW_ALU_OE;
    localparam ctrl_word_t M_ALU_SUB   = ctrl_word_t'(1) << CW_ALU_SUB;
    localparam ctrl_word_t M_FLAG_LOAD = ctrl_word_t'(1) << CW_FLAG_LOAD;
    localparam ctrl_word_t M_OUT_LOAD  = ctrl_word_t'(1) << CW_OUT_LOAD;

    localparam ctrl_word_t W_FETCH0 = M_PC_OE | M_MAR_LOAD;
    localparam ctrl_word_t W_FETCH1 = M_RAM_OE | M_IR_LOAD | M_PC_INC;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                clr = 1'b1;
    logic [OPCODE_W-1:0] opcode = '0;
    logic                carry_flag = 1'b0;
    logic                zero_flag = 1'b0;
    logic [STEP_W-1:0]   step;
    logic halt, pc_inc, pc_jump, pc_oe, mar_load, ram_oe, ram_we, ir_load, ir_oe;
    logic a_load, a_oe, b_load, alu_oe, alu_sub, flag_load, out_load;

    control_sequencer dut (
        .clk(clk), .clr(clr), .opcode(opcode), .carry_flag(carry_flag), .zero_flag(zero_flag),
        .step(step), .halt(halt), .pc_inc(pc_inc), .pc_jump(pc_jump), .pc_oe(pc_oe),
        .mar_load(mar_load), .ram_oe(ram_oe), .ram_we(ram_we), .ir_load(ir_load), .ir_oe(ir_oe),
        .a_load(a_load), .a_oe(a_oe), .b_load(b_load), .alu_oe(alu_oe), .alu_sub(alu_sub),
        .flag_load(flag_load), .out_load(out_load)
    );

    ctrl_word_t act_cw;
    always_comb begin
        act_cw = '0;
        act_cw[CW_PC_INC]    = pc_inc;
        act_cw[CW_PC_JUMP]   = pc_jump;
        act_cw[CW_PC_OE]     = pc_oe;
        act_cw[CW_MAR_LOAD]  = mar_load;
        act_cw[CW_RAM_OE]    = ram_oe;
        act_cw[CW_RAM_WE]    = ram_we;
        act_cw[CW_IR_LOAD]   = ir_load;
        act_cw[CW_IR_OE]     = ir_oe;
        act_cw[CW_A_LOAD]    = a_load;
        act_cw[CW_A_OE]      = a_oe;
        act_cw[CW_B_LOAD]    = b_load;
        act_cw[CW_ALU_OE]    = alu_oe;
        act_cw[CW_ALU_SUB]   = alu_sub;
        act_cw[CW_FLAG_LOAD] = flag_load;
        act_cw[CW_OUT_LOAD]  = out_load;
    end

    obs_t obs;
    assign obs = {step, halt, act_cw};

    int tests  = 0;
    int failed = 0;
    bit mon_en = 1'b0;

    // Reference model: instruction-level table plus cycle arithmetic.
    ctrl_word_t rom [16][5];
    int         m_step   = 0;
    logic       m_halted = 1'b0;

    task automatic build_rom();
        for (int op = 0; op < 16; op++) begin
            for (int t = 0; t < 5; t++) rom[op][t] = '0;
            rom[op][0] = W_FETCH0;
            rom[op][1] = W_FETCH1;
        end
        rom[OP_LDA][2] = M_IR_OE | M_MAR_LOAD;  rom[OP_LDA][3] = M_RAM_OE | M_A_LOAD;
        rom[OP_ADD][2] = M_IR_OE | M_MAR_LOAD;  rom[OP_ADD][3] = M_RAM_OE | M_B_LOAD;
        rom[OP_ADD][4] = M_ALU_OE | M_A_LOAD | M_FLAG_LOAD;
        rom[OP_SUB][2] = M_IR_OE | M_MAR_LOAD;  rom[OP_SUB][3] = M_RAM_OE | M_B_LOAD;
        rom[OP_SUB][4] = M_ALU_OE | M_A_LOAD | M_FLAG_LOAD | M_ALU_SUB;
        rom[OP_STA][2] = M_IR_OE | M_MAR_LOAD;  rom[OP_STA][3] = M_A_OE | M_RAM_WE;
        rom[OP_LDI][2] = M_IR_OE | M_A_LOAD;
        rom[OP_JMP][2] = M_IR_OE | M_PC_JUMP;
        rom[OP_JC][2]  = M_IR_OE | M_PC_JUMP;
        rom[OP_JZ][2]  = M_IR_OE | M_PC_JUMP;
        rom[OP_OUT][2] = M_A_OE | M_OUT_LOAD;
    endtask

    function automatic obs_t model_obs();
        ctrl_word_t w;
        if (clr || m_halted) begin
            w = '0;
        end else begin
            w = rom[opcode][m_step];
            if (m_step == 2 && ((opcode == OP_JC && !carry_flag) || (opcode == OP_JZ && !zero_flag)))
                w = '0;
        end
        return {STEP_W'(m_step), m_halted, w};
    endfunction

    // driver: one clock edge, model follows the inputs seen at that edge
    task automatic advance();
        @(posedge clk);
        if (clr) begin
            m_step = 0;
            m_halted = 1'b0;
        end else if (!m_halted) begin
            if (m_step == 2 && opcode == OP_HLT) m_halted = 1'b1;
            else m_step = (m_step + 1) % 5;
        end
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        carry_flag = 1'b0;
        zero_flag = 1'b0;
        advance();
        clr = 1'b0;
        mon_en = 1'b1;
    endtask

    // bus-driver one-hot and pc_inc/pc_jump exclusivity, every cycle
    always @(negedge clk) begin
        if (mon_en) begin
            tests++;
            if ($countones({pc_oe, ram_oe, ir_oe, a_oe, alu_oe}) > 1 || (pc_inc && pc_jump)) begin
                failed++;
                $display("FAIL bus_exclusive: got drivers=%b inc/jump=%b%b want at most one driver, not both",
                         {pc_oe, ram_oe, ir_oe, a_oe, alu_oe}, pc_inc, pc_jump);
            end
        end
    end

    task automatic test_reset();
        obs_t exp;
        clr = 1'b1;
        opcode = OP_ADD;
        #1;
        tests++;
        if (act_cw !== '0) begin
            failed++; $display("FAIL reset_forced_zero: got %h want 0", act_cw);
        end
        advance();
        advance();
        clr = 1'b0;
        mon_en = 1'b1;
        #1;
        exp = {3'd0, 1'b0, W_FETCH0};
        tests++;
        if (obs !== exp) begin
            failed++; $display("FAIL reset_t0: got %h want %h", obs, exp);
        end
        advance();
        exp = {3'd1, 1'b0, W_FETCH1};
        tests++;
        if (obs !== exp) begin
            failed++; $display("FAIL reset_t1: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_add();
        ctrl_word_t ew[5];
        obs_t exp;
        ew = '{W_FETCH0, W_FETCH1, M_IR_OE | M_MAR_LOAD, M_RAM_OE | M_B_LOAD,
               M_ALU_OE | M_A_LOAD | M_FLAG_LOAD};
        do_reset();
        opcode = OP_ADD;
        for (int t = 0; t < 5; t++) begin
            #1;
            exp = {STEP_W'(t), 1'b0, ew[t]};
            tests++;
            if (obs !== exp) begin
                failed++; $display("FAIL add_t%0d: got %h want %h", t, obs, exp);
            end
            advance();
        end
        exp = {3'd0, 1'b0, W_FETCH0};
        tests++;
        if (obs !== exp) begin
            failed++; $display("FAIL add_wrap: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_cond_jump();
        obs_t exp;
        do_reset();
        opcode = OP_JC;
        advance(); advance();
        exp = {3'd2, 1'b0, ctrl_word_t'(0)};
        tests++;
        if (obs !== exp) begin
            failed++; $display("FAIL jc_not_taken: got %h want %h", obs, exp);
        end
        advance(); advance(); advance();
        carry_flag = 1'b1;
        advance(); advance();
        exp = {3'd2, 1'b0, M_IR_OE | M_PC_JUMP};
        tests++;
        if (obs !== exp) begin
            failed++; $display("FAIL jc_taken: got %h want %h", obs, exp);
        end
        carry_flag = 1'b0;  // flag drops mid-T2
        #1;
        exp = {3'd2, 1'b0, ctrl_word_t'(0)};
        tests++;
        if (obs !== exp) begin
            failed++; $display("FAIL jc_flag_live: got %h want %h", obs, exp);
        end
        advance(); advance(); advance();
        opcode = OP_JZ;
        zero_flag = 1'b1;
        advance(); advance();
        exp = {3'd2, 1'b0, M_IR_OE | M_PC_JUMP};
        tests++;
        if (obs !== exp) begin
            failed++; $display("FAIL jz_taken: got %h want %h", obs, exp);
        end
        advance(); advance(); advance();
        zero_flag = 1'b0;
    endtask

    task automatic test_halt();
        obs_t exp;
        do_reset();
        opcode = OP_HLT;
        advance(); advance();
        exp = {3'd2, 1'b0, ctrl_word_t'(0)};
        tests++;
        if (obs !== exp) begin
            failed++; $display("FAIL hlt_t2: got %h want %h", obs, exp);
        end
        for (int i = 0; i < 10; i++) begin
            advance();
            opcode = 4'($urandom_range(0, 15));
            carry_flag = 1'($urandom_range(0, 1));
            zero_flag = 1'($urandom_range(0, 1));
            #1;
            exp = {3'd2, 1'b1, ctrl_word_t'(0)};
            tests++;
            if (obs !== exp) begin
                failed++; $display("FAIL hlt_hold_%0d: got %h want %h", i, obs, exp);
            end
        end
        clr = 1'b1;
        advance();
        clr = 1'b0;
        #1;
        exp = {3'd0, 1'b0, W_FETCH0};
        tests++;
        if (obs !== exp) begin
            failed++; $display("FAIL hlt_exit: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_reset_mid();
        obs_t exp;
        do_reset();
        opcode = OP_SUB;
        advance(); advance(); advance();
        clr = 1'b1;
        #1;
        tests++;
        if (act_cw !== '0) begin
            failed++; $display("FAIL mid_clr_forced: got %h want 0", act_cw);
        end
        advance();
        clr = 1'b0;
        #1;
        exp = {3'd0, 1'b0, W_FETCH0};
        tests++;
        if (obs !== exp) begin
            failed++; $display("FAIL mid_clr_t0: got %h want %h", obs, exp);
        end
        advance();
        tests++;
        if (alu_oe !== 1'b0 || alu_sub !== 1'b0) begin
            failed++; $display("FAIL mid_clr_no_t4: got alu_oe=%b alu_sub=%b want 0 0", alu_oe, alu_sub);
        end
    endtask

    task automatic test_undefined();
        obs_t exp;
        do_reset();
        opcode = 4'b1010;
        advance(); advance();
        for (int t = 2; t < 5; t++) begin
            #1;
            exp = {STEP_W'(t), 1'b0, ctrl_word_t'(0)};
            tests++;
            if (obs !== exp) begin
                failed++; $display("FAIL undef_t%0d: got %h want %h", t, obs, exp);
            end
            advance();
        end
        exp = {3'd0, 1'b0, W_FETCH0};
        tests++;
        if (obs !== exp) begin
            failed++; $display("FAIL undef_next_t0: got %h want %h", obs, exp);
        end
        advance();
        exp = {3'd1, 1'b0, W_FETCH1};
        tests++;
        if (obs !== exp) begin
            failed++; $display("FAIL undef_next_t1: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_sweep();
        for (int op = 0; op < 16; op++) begin
            do_reset();
            opcode = 4'(op);
            carry_flag = 1'($urandom_range(0, 1));
            zero_flag = 1'($urandom_range(0, 1));
            for (int c = 0; c < 7; c++) begin
                #1;
                tests++;
                if (obs !== model_obs()) begin
                    failed++; $display("FAIL sweep_op%0d_c%0d: got %h want %h", op, c, obs, model_obs());
                end
                advance();
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            clr = ($urandom_range(0, 39) == 0);
            opcode = 4'($urandom_range(0, 15));
            carry_flag = 1'($urandom_range(0, 1));
            zero_flag = 1'($urandom_range(0, 1));
            #1;
            tests++;
            if (obs !== model_obs()) begin
                failed++; $display("FAIL random_%0d: got %h want %h", i, obs, model_obs());
            end
            advance();
        end
        clr = 1'b0;
    endtask

    initial begin
        build_rom();
        test_reset();
        test_add();
        test_cond_jump();
        test_halt();
        test_reset_mid();
        test_undefined();
        test_sweep();
        test_random();
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
